// File: rtl/key_driver_pkg.sv
// Shared definitions for the key conditioning block: per-key FSM states
// and default timing constants (50 MHz system clock).
package key_driver_pkg;

  typedef enum logic [1:0] {
    IDLE           = 2'd0,
    PRESS_FILTER   = 2'd1,
    DOWN           = 2'd2,
    RELEASE_FILTER = 2'd3
  } key_state_t;

  localparam int unsigned DEF_KEY_NUM      = 4;
  localparam int unsigned DEF_DEBOUNCE_CNT = 1_000_000;  // 20 ms
  localparam int unsigned DEF_LONG_CNT     = 50_000_000; // 1 s

endpackage

// File: rtl/key_driver_filter.sv
// Single-key conditioner: two-flop synchroniser, debounce FSM, hold counter
// and registered level/press/release/long-press outputs.
module key_filter
  import key_driver_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CNT = DEF_DEBOUNCE_CNT,
  parameter int unsigned LONG_CNT     = DEF_LONG_CNT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic key_long
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CNT);
  localparam int unsigned HW = $clog2(LONG_CNT);
  localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CNT - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CNT - 1);
  localparam logic [HW-1:0] HOLD_PRE  = HW'(LONG_CNT - 2);

  logic sync1, key_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      key_s <= 1'b1;
    end else begin
      sync1 <= key;
      key_s <= sync1;
    end
  end

  key_state_t    state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [HW-1:0] hold_cnt, hold_next;
  logic          level_next, press_next, release_next, long_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      hold_cnt    <= '0;
      key_level   <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
      key_long    <= 1'b0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      hold_cnt    <= hold_next;
      key_level   <= level_next;
      key_press   <= press_next;
      key_release <= release_next;
      key_long    <= long_next;
    end
  end

  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    hold_next    = hold_cnt;
    level_next   = key_level;
    press_next   = 1'b0;
    release_next = 1'b0;
    long_next    = 1'b0;
    unique case (state)
      IDLE: begin
        if (!key_s) begin
          state_next = PRESS_FILTER;
          cnt_next   = '0;
        end
      end
      PRESS_FILTER: begin
        if (key_s) begin
          state_next = IDLE;
        end else if (cnt == CNT_LAST) begin
          state_next = DOWN;
          press_next = 1'b1;
          level_next = 1'b1;
          hold_next  = '0;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      DOWN: begin
        // Saturating hold count; the pulse marks the single step into the last value.
        if (hold_cnt != HOLD_LAST) begin
          hold_next = hold_cnt + HW'(1);
          long_next = (hold_cnt == HOLD_PRE);
        end
        if (key_s) begin
          state_next = RELEASE_FILTER;
          cnt_next   = '0;
        end
      end
      RELEASE_FILTER: begin
        if (!key_s) begin
          state_next = DOWN;
        end else if (cnt == CNT_LAST) begin
          state_next   = IDLE;
          release_next = 1'b1;
          level_next   = 1'b0;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: rtl/key_driver.sv
// Push-button front end: one independent key_filter per board key pin.
module key_driver
  import key_driver_pkg::*;
#(
  parameter int unsigned KEY_NUM      = DEF_KEY_NUM,
  parameter int unsigned DEBOUNCE_CNT = DEF_DEBOUNCE_CNT,
  parameter int unsigned LONG_CNT     = DEF_LONG_CNT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [KEY_NUM-1:0] key,
  output logic [KEY_NUM-1:0] key_level,
  output logic [KEY_NUM-1:0] key_press,
  output logic [KEY_NUM-1:0] key_release,
  output logic [KEY_NUM-1:0] key_long
);

  for (genvar i = 0; i < KEY_NUM; i++) begin : g_key
    key_filter #(
      .DEBOUNCE_CNT(DEBOUNCE_CNT),
      .LONG_CNT    (LONG_CNT)
    ) u_filter (
      .clk        (clk),
      .rst_n      (rst_n),
      .key        (key[i]),
      .key_level  (key_level[i]),
      .key_press  (key_press[i]),
      .key_release(key_release[i]),
      .key_long   (key_long[i])
    );
  end

endmodule

// File: tb/tb_key_driver.sv
// Bench for key_driver: directed scenarios plus randomized key traffic,
// checked every cycle against a run-length model of the debouncer.
module tb_key_driver;

  localparam int unsigned KN = 4;
  localparam int unsigned D  = 4;
  localparam int unsigned L  = 20;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [KN-1:0] key;
  logic [KN-1:0] key_level, key_press, key_release, key_long;

  key_driver #(
    .KEY_NUM     (KN),
    .DEBOUNCE_CNT(D),
    .LONG_CNT    (L)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key        (key),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release),
    .key_long   (key_long)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: pins reach the decision point two clocks late; a level flips
  // when the opposite value has been seen D+1 times in a row; hold time
  // accumulates over cycles where the key was last seen down while pressed.
  logic [KN-1:0] m_s1, m_s2, m_last, m_prev, m_level;
  logic [KN-1:0] e_press, e_rel, e_long;
  int            m_run [KN];
  int            m_hold[KN];

  task automatic model_reset();
    m_s1 = '1; m_s2 = '1; m_last = '1; m_prev = '1;
    m_level = '0; e_press = '0; e_rel = '0; e_long = '0;
    for (int i = 0; i < KN; i++) begin
      m_run[i]  = 0;
      m_hold[i] = 0;
    end
  endtask

  task automatic model_update();
    logic x;
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int i = 0; i < KN; i++) begin
      x = m_s2[i];
      e_press[i] = 1'b0; e_rel[i] = 1'b0; e_long[i] = 1'b0;
      if (m_level[i] && !m_prev[i] && m_hold[i] < int'(L) - 1) begin
        m_hold[i]++;
        if (m_hold[i] == int'(L) - 1) e_long[i] = 1'b1;
      end
      if (x == m_last[i]) m_run[i] = (m_run[i] > int'(D) + 1) ? m_run[i] : m_run[i] + 1;
      else                m_run[i] = 1;
      m_last[i] = x;
      if (!m_level[i] && !x && m_run[i] == int'(D) + 1) begin
        e_press[i] = 1'b1; m_level[i] = 1'b1; m_hold[i] = 0;
      end else if (m_level[i] && x && m_run[i] == int'(D) + 1) begin
        e_rel[i] = 1'b1; m_level[i] = 1'b0;
      end
      m_prev[i] = x;
    end
    m_s2 = m_s1;
    m_s1 = key;
  endtask

  int cyc = 0;

  task automatic step();
    @(posedge clk);
    cyc++;
    model_update();
    #1;
    check("level",   32'(key_level),   32'(m_level));
    check("press",   32'(key_press),   32'(e_press));
    check("release", 32'(key_release), 32'(e_rel));
    check("long",    32'(key_long),    32'(e_long));
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_level"},   32'(key_level),   0);
    check({tag, "_press"},   32'(key_press),   0);
    check({tag, "_release"}, 32'(key_release), 0);
    check({tag, "_long"},    32'(key_long),    0);
  endtask

  initial begin
    int first;
    int n_press, n_long, n_rel;
    logic seen;
    int unsigned left[KN];

    rst_n = 1'b0;
    key   = '1;
    model_reset();
    steps(3);
    check_all_zero("reset");
    rst_n = 1'b1;
    steps(5);

    // Clean press on key 0, then release
    key[0] = 1'b0;
    first = 0;
    for (int k = 1; k <= 30; k++) begin
      step();
      if (key_press[0] && first == 0) first = k;
    end
    check("press_latency", 32'(first), 32'(D + 3));
    key[0] = 1'b1;
    first = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (key_release[0] && first == 0) first = k;
    end
    check("release_latency", 32'(first), 32'(D + 3));

    // Bounce on key 1: low 3, high 2, low 3, high
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      key[1] = (k < 3 || (k >= 5 && k < 8)) ? 1'b0 : 1'b1;
      step();
      if (key_press[1] || key_level[1]) seen = 1'b1;
    end
    check("bounce_rejected", 32'(seen), 0);

    // Long hold on key 2
    n_press = 0; n_long = 0; n_rel = 0;
    key[2] = 1'b0;
    for (int k = 0; k < 40; k++) begin
      step();
      n_press += int'(key_press[2]);
      n_long  += int'(key_long[2]);
    end
    key[2] = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      n_rel  += int'(key_release[2]);
      n_long += int'(key_long[2]);
    end
    check("long_press_count",   32'(n_press), 1);
    check("long_pulse_count",   32'(n_long),  1);
    check("long_release_count", 32'(n_rel),   1);

    // Release bounce on key 0 while DOWN
    key[0] = 1'b0;
    steps(12);
    key[0] = 1'b1;
    steps(2);
    key[0] = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 30; k++) begin
      step();
      if (key_release[0] || !key_level[0]) seen = 1'b1;
    end
    check("release_bounce", 32'(seen), 0);
    key[0] = 1'b1;
    steps(15);

    // Simultaneous press on all keys
    key = '0;
    first = 0;
    for (int k = 1; k <= 30 && first == 0; k++) begin
      step();
      if (key_press != '0) first = k;
    end
    check("simultaneous_press", 32'(key_press), 32'hF);
    steps(4);

    // Reset while held: async clear, then a fresh debounce with no release
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    steps(2);
    rst_n = 1'b1;
    first = 0;
    seen  = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      step();
      if (key_press[0] && first == 0) first = k;
      if (key_release != '0) seen = 1'b1;
    end
    check("reset_repress_latency", 32'(first), 32'(D + 3));
    check("reset_no_release", 32'(seen), 0);
    key = '1;
    steps(20);

    // Random traffic: mix of short bounces and long holds per key
    for (int i = 0; i < KN; i++) left[i] = $urandom_range(1, 10);
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < KN; i++) begin
        if (left[i] == 0) begin
          key[i]  = ~key[i];
          left[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 60) : $urandom_range(1, 8);
        end else begin
          left[i]--;
        end
      end
      if (c == 1500) begin
        #2 rst_n = 1'b0;
        #1 check_all_zero("rand_reset");
        step();
        rst_n = 1'b1;
      end else begin
        step();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
